// File: rtl/out_fm_st_tile_counter_pkg.sv
// Shared types and constants for the output-FM store tile walker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package out_fm_st_pkg;

  localparam int DEF_CW = 16;
  localparam int DEF_AW = 32;
  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Saturating increment for the perf counters: sticks at all-ones.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/out_fm_st_tile_counter_if.sv
// Job/beat bundle between the store controller (master) and the tile walker (slave).
// Latency: n/a (wiring only).
// Backpressure: ena is the consumer ready for the valid beat.
interface out_fm_st_tile_counter_if
  import out_fm_st_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int AW = DEF_AW
) ();

  // job request side
  logic          start;
  logic          clean;
  logic [CW-1:0] n0_max;
  logic [CW-1:0] n1_max;
  logic [CW-1:0] n2_max;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride1;
  logic [AW-1:0] stride2;
  logic          ena;

  // beat / status side
  logic          valid;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic [AW-1:0] addr;
  logic          last;
  logic          busy;
  logic          done;

  modport master (
    output start, clean, n0_max, n1_max, n2_max, base_addr, stride1, stride2, ena,
    input  valid, cnt0, cnt1, cnt2, addr, last, busy, done
  );

  modport slave (
    input  start, clean, n0_max, n1_max, n2_max, base_addr, stride1, stride2, ena,
    output valid, cnt0, cnt1, cnt2, addr, last, busy, done
  );

endinterface

// File: rtl/out_fm_st_tile_counter_wrap_cnt.sv
// One wrapping counter level: counts 0..max-1 on inc, flags wrap on the final step.
// Latency: val updates the cycle after inc; wrap is combinational from val/max/inc.
// Backpressure: none; inc is the only advance condition.
module wrap_cnt
  import out_fm_st_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] val,
  output logic          wrap
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] val_q;
  logic          at_end;

  assign at_end = (val_q == (max - ONE));
  assign wrap   = inc && at_end;
  assign val    = val_q;

  // count up on inc, fold back to 0 after max-1; clr wins over inc
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val_q <= '0;
    end else if (inc) begin
      val_q <= at_end ? '0 : val_q + ONE;
    end
  end

endmodule

// File: rtl/out_fm_st_tile_counter.sv
// Store-side 3-level tile walker: emits cnt0/cnt1/cnt2 and a linear addr per beat.
// Latency: first beat valid the cycle after start; one beat per cycle; done 1 cycle after last.
// Backpressure: beat held stable while ena=0; advances only on valid&&ena.
// Optional build macro OUT_FM_ST_PERF_EN adds beat_cnt/stall_cnt perf outputs.
module out_fm_st_tile_counter
  import out_fm_st_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int AW = DEF_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  out_fm_st_tile_counter_if.slave  bus
`ifdef OUT_FM_ST_PERF_EN
  ,
  output logic [PERF_W-1:0]        beat_cnt,
  output logic [PERF_W-1:0]        stall_cnt
`endif
);

  localparam logic [CW-1:0] CONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] AONE = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;

  // job parameters captured at start; plane_q doubles as the latched base
  logic [CW-1:0] n0_q, n1_q, n2_q;
  logic [AW-1:0] s1_q, s2_q;
  logic [AW-1:0] plane_q, row_q, addr_q;

  logic [CW-1:0] cnt0_w, cnt1_w, cnt2_w;
  logic          wrap0, wrap1, wrap2;

  logic          valid_w;
  logic          start_acc;
  logic          beat;
  logic          zero_len;
  logic          cnt_clr;

  assign valid_w   = (state_q == ST_RUN);
  assign start_acc = (state_q == ST_IDLE) && bus.start && !bus.clean;
  assign beat      = valid_w && bus.ena && !bus.clean;
  assign zero_len  = (bus.n0_max == '0) || (bus.n1_max == '0) || (bus.n2_max == '0);
  assign cnt_clr   = bus.clean || start_acc;

  wrap_cnt #(.CW(CW)) u_cnt0 (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (beat),
    .max  (n0_q),
    .val  (cnt0_w),
    .wrap (wrap0)
  );

  wrap_cnt #(.CW(CW)) u_cnt1 (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (wrap0),
    .max  (n1_q),
    .val  (cnt1_w),
    .wrap (wrap1)
  );

  wrap_cnt #(.CW(CW)) u_cnt2 (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (wrap1),
    .max  (n2_q),
    .val  (cnt2_w),
    .wrap (wrap2)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: clean aborts from anywhere, zero-length jobs skip straight to FIN
  always_comb begin
    state_d = state_q;
    if (bus.clean) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start) state_d = zero_len ? ST_FIN : ST_RUN;
        ST_RUN:  if (wrap2)     state_d = ST_FIN;
        ST_FIN:                 state_d = ST_IDLE;
        default:                state_d = ST_IDLE;
      endcase
    end
  end

  // job latch and incremental address walk (row/plane bases replace multipliers)
  always_ff @(posedge clk) begin
    if (rst) begin
      n0_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      plane_q <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else if (bus.clean) begin
      plane_q <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else if (start_acc) begin
      n0_q    <= bus.n0_max;
      n1_q    <= bus.n1_max;
      n2_q    <= bus.n2_max;
      s1_q    <= bus.stride1;
      s2_q    <= bus.stride2;
      plane_q <= bus.base_addr;
      row_q   <= bus.base_addr;
      addr_q  <= bus.base_addr;
    end else if (beat) begin
      if (!wrap0) begin
        addr_q <= addr_q + AONE;
      end else if (!wrap1) begin
        row_q  <= row_q + s1_q;
        addr_q <= row_q + s1_q;
      end else begin
        plane_q <= plane_q + s2_q;
        row_q   <= plane_q + s2_q;
        addr_q  <= plane_q + s2_q;
      end
    end
  end

  assign bus.valid = valid_w;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_FIN);
  assign bus.cnt0  = cnt0_w;
  assign bus.cnt1  = cnt1_w;
  assign bus.cnt2  = cnt2_w;
  assign bus.addr  = addr_q;
  assign bus.last  = valid_w &&
                     (cnt0_w == (n0_q - CONE)) &&
                     (cnt1_w == (n1_q - CONE)) &&
                     (cnt2_w == (n2_q - CONE));

`ifdef OUT_FM_ST_PERF_EN
  logic [PERF_W-1:0] beat_q, stall_q;

  // consumed beats and stalled cycles, zeroed per job, saturating, held after done
  always_ff @(posedge clk) begin
    if (rst || bus.clean || start_acc) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else if (valid_w) begin
      if (bus.ena) beat_q  <= sat_inc(beat_q);
      else         stall_q <= sat_inc(stall_q);
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`endif

endmodule
